hop_lane_checker: RTL



---
 rtl/hop_lane_checker.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hop_lane_checker.sv
// Stimulus source and return-path checker for multi-lane flop-hop paths.
// Drives an LFSR vector on start each RUN cycle and checks ff_in after HOP_LAT.
//
// Ports:
//   clock0        rising-edge clock
//   rst1          synchronous active-low reset
//   go            run request, honoured in IDLE or DONE only
//   start         stimulus vector to the lane launch flops (0 when not in RUN)
//   ff_in         returned lane outputs
//   busy          high in RUN and DRAIN
//   done          high in DONE
//   pass          valid in DONE: no mismatching vector this run
//   err_count     mismatching vectors this run, saturating at 16'hFFFF
//   lane_err      sticky per-lane mismatch flags this run
//   first_err_idx index of the first mismatching vector, 16'hFFFF if none
//                 (present only with HOP_LANE_CHECKER_FIRST_ERR_EN defined)
//
// Optional feature macro: HOP_LANE_CHECKER_FIRST_ERR_EN.

module hop_lane_checker #(
  parameter int          LANES       = 4,
  parameter int          HOP_LAT     = 2,
  parameter int          NUM_VECTORS = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic             go,
  output logic [LANES-1:0] start,
  input  logic [LANES-1:0] ff_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [LANES-1:0] lane_err
`ifdef HOP_LANE_CHECKER_FIRST_ERR_EN
  ,
  output logic [15:0]      first_err_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  DRAIN_END = 4'(HOP_LAT);

  // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] vcnt;
  logic [3:0]  dcnt;
  logic        emit;

  // start/emit form stage 0; pv/pd are the HOP_LAT-deep expected-vector
  // delay line. The tail is compared against ff_in.
  logic [HOP_LAT:1] pv;
  logic [LANES-1:0] pd [1:HOP_LAT];

  logic             tail_v;
  logic [LANES-1:0] diff;
  logic             mis;

  always_comb begin
    tail_v = pv[HOP_LAT];
    diff   = '0;
    if (tail_v) diff = ff_in ^ pd[HOP_LAT];
    mis    = |diff;
  end

`ifdef HOP_LANE_CHECKER_FIRST_ERR_EN
  logic [15:0] cmp_idx;
`endif

  always_ff @(posedge clock0) begin
    if (!rst1) begin
      state     <= S_IDLE;
      lfsr      <= LFSR_SEED;
      vcnt      <= '0;
      dcnt      <= '0;
      emit      <= 1'b0;
      start     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      lane_err  <= '0;
      pv        <= '0;
      for (int j = 1; j <= HOP_LAT; j++) pd[j] <= '0;
`ifdef HOP_LANE_CHECKER_FIRST_ERR_EN
      first_err_idx <= 16'hFFFF;
      cmp_idx       <= '0;
`endif
    end else begin
      pv[1] <= emit;
      pd[1] <= start;
      for (int j = 2; j <= HOP_LAT; j++) begin
        pv[j] <= pv[j-1];
        pd[j] <= pd[j-1];
      end

      if (mis) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        lane_err <= lane_err | diff;
      end

`ifdef HOP_LANE_CHECKER_FIRST_ERR_EN
      if (tail_v) cmp_idx <= cmp_idx + 16'd1;
      if (mis && first_err_idx == 16'hFFFF) first_err_idx <= cmp_idx;
`endif

      unique case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state     <= S_RUN;
            start     <= LFSR_SEED[LANES-1:0];
            lfsr      <= lfsr_step(LFSR_SEED);
            emit      <= 1'b1;
            vcnt      <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            lane_err  <= '0;
`ifdef HOP_LANE_CHECKER_FIRST_ERR_EN
            first_err_idx <= 16'hFFFF;
            cmp_idx       <= '0;
`endif
          end
        end
        S_RUN: begin
          if (vcnt == LAST_VEC) begin
            state <= S_DRAIN;
            start <= '0;
            emit  <= 1'b0;
            dcnt  <= '0;
          end else begin
            start <= lfsr[LANES-1:0];
            lfsr  <= lfsr_step(lfsr);
            vcnt  <= vcnt + 16'd1;
          end
        end
        S_DRAIN: begin
          // Last compare lands on the edge where dcnt reaches DRAIN_END-1's
          // successor, so err_count is final when DONE is entered.
          if (dcnt == DRAIN_END) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0);
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
